pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, meaning total EX cycles occupied by MUL (range 1..15).
REQ-002 SHALL have parameter DIV_LAT, default 8, meaning total EX cycles occupied by DIV and MOD (range 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses this single clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port of_instr  input  address_reg  register fields of the instruction in the OF stage.
REQ-006 SHALL have port ex_instr  input  address_reg  register fields of the instruction in the EX stage.
REQ-007 SHALL have port ex_ctrl  input  control_signal  decoded control of the EX-stage instruction.
REQ-008 SHALL have port ex_branch_taken  input  1  branch or call resolved taken in EX.
REQ-009 SHALL have port mem_wait  input  1  data memory not ready; the whole pipe freezes.
REQ-010 SHALL have port hold_front  output  1  hold the PC and the IF/OF latch.
REQ-011 SHALL have port hold_ex  output  1  hold the OF/EX latch.
REQ-012 SHALL have port hold_all  output  1  freeze every pipeline latch.
REQ-013 SHALL have port bubble_ex  output  1  load NOP (valid=0) into the OF/EX latch.
REQ-014 SHALL have port bubble_ma  output  1  load NOP into the EX/MA latch.
REQ-015 SHALL have port flush_front  output  1  invalidate the IF/OF and OF/EX latches.
REQ-016 SHALL have port ld_use_conflict  output  1  load-use hazard detected this cycle.
REQ-017 SHALL have port md_done  output  1  one-cycle pulse on the final MUL/DIV/MOD cycle.

Function
REQ-018 SHALL detect a load-use hazard when all of the following hold: ex_instr.valid, ex_ctrl.isLd, of_instr.valid, and ex_instr.rd matches any of: of_instr.rs1; of_instr.rs2 when I_bit=0; of_instr.rd when of_instr.opcode=ST.
REQ-019 SHALL implement FSM states IDLE, MD_BUSY and FREEZE.
REQ-020 SHALL, in IDLE, start a multicycle operation when ex_instr.valid and (isMul or isDiv or isMod) and mem_wait=0: load the counter with LAT-1, go to MD_BUSY, assert hold_front, hold_ex and bubble_ma.
REQ-021 SHALL treat LAT=1 as a single-cycle operation: no MD_BUSY entry, md_done asserted in the same cycle.
REQ-022 SHALL, in MD_BUSY, decrement the counter each cycle while holding hold_front, hold_ex and bubble_ma; at count 1, assert md_done with all holds released and return to IDLE, so the operation occupies exactly LAT cycles.
REQ-023 SHALL, when mem_wait=1 in any state, assert only hold_all, go to FREEZE, retain the counter and return state, and resume the saved state unchanged when mem_wait falls.
REQ-024 SHALL, in IDLE with no multicycle operation, assert flush_front for exactly one cycle when ex_branch_taken=1.
REQ-025 SHALL, in IDLE with no branch or multicycle start, assert ld_use_conflict, hold_front and bubble_ex for exactly one cycle on a load-use hazard.
REQ-026 SHALL apply the priority mem_wait > multicycle > branch flush > load-use, so that only one action is asserted per cycle.
REQ-027 SHALL derive all outputs combinationally from the current state and inputs, with no output registers.

Reset
REQ-028 SHALL, while rst_n=0, force the state to IDLE, the counter to 0 and every output to 0.
REQ-029 SHALL abandon a reset asserted mid-MD_BUSY or mid-FREEZE with no md_done pulse.

Configuration
REQ-030 SHALL, with macro MULDIV_STALL_EN defined, implement the multicycle behaviour of REQ-020..022.
REQ-031 SHALL, with MULDIV_STALL_EN undefined, treat MUL/DIV/MOD as single-cycle, never enter MD_BUSY, and pulse md_done on every valid MUL/DIV/MOD in EX.

Structure
REQ-032 SHALL add a hazard_state enum (IDLE, MD_BUSY, FREEZE), MUL_LAT_DEF=2 and DIV_LAT_DEF=8 to riscv_params_pkg.
REQ-033 SHALL place the combinational load-use comparator in sub-module ld_use_detect.

Verification
REQ-034 SHALL be verified with: EX=LD rd=3, OF=ADD rs1=3 -> ld_use_conflict, hold_front and bubble_ex high for 1 cycle; next cycle all low.
REQ-035 SHALL be verified with: EX=ADD I_bit=1 rs2=3, OF rs2=3 with I_bit=1 -> no stall.
REQ-036 SHALL be verified with: EX=DIV, DIV_LAT=8 -> hold_front high for 7 cycles, md_done on the 8th cycle.
REQ-037 SHALL be verified with: mem_wait high for 3 cycles during MD_BUSY at count 4 -> hold_all for 3 cycles, resume at count 4, total occupancy 11 cycles.
REQ-038 SHALL be verified with: ex_branch_taken=1 -> flush_front high for 1 cycle, no bubble_ex.
REQ-039 SHALL be verified with: rst_n low mid-MUL -> all outputs 0 immediately; after release, state IDLE with no md_done.

Source files
------------

// File: rtl/riscv_params_pkg.sv
// Shared pipeline types for the RISC-style core: instruction register
// fields, decoded EX control, opcodes used by hazard logic, and the
// hazard controller state encoding with default multicycle latencies.
package riscv_params_pkg;

    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned DIV_LAT_DEF = 8;

    localparam int REG_AW = 5;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OP_LD  = 5'd2;
    localparam logic [OPC_W-1:0] OP_ST  = 5'd3;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd4;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd5;
    localparam logic [OPC_W-1:0] OP_MOD = 5'd6;
    localparam logic [OPC_W-1:0] OP_BEQ = 5'd7;

    // Register fields carried by each pipeline latch
    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic              I_bit;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } address_reg;

    // Decoded control of the instruction sitting in EX
    typedef struct packed {
        logic isLd;
        logic isSt;
        logic isMul;
        logic isDiv;
        logic isMod;
        logic isBranch;
    } control_signal;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        FREEZE  = 2'd2
    } hazard_state;

endpackage

// File: rtl/ld_use_detect.sv
// Combinational load-use comparator: flags when the load in EX writes a
// register that the OF-stage instruction reads (rs1, rs2 when not
// immediate, or rd as the store data source).
module ld_use_detect
    import riscv_params_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_is_ld,
    input  logic [REG_AW-1:0] ex_rd,
    input  address_reg        of_instr,
    output logic              hazard
);

    logic match_rs1;
    logic match_rs2;
    logic match_st;

    assign match_rs1 = (ex_rd == of_instr.rs1);
    assign match_rs2 = !of_instr.I_bit && (ex_rd == of_instr.rs2);
    assign match_st  = (of_instr.opcode == OP_ST) && (ex_rd == of_instr.rd);

    assign hazard = ex_valid && ex_is_ld && of_instr.valid
                    && (match_rs1 || match_rs2 || match_st);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, multicycle MUL/DIV/MOD
// stalls, taken-branch flush and load-use bubbles, in that priority.
// Outputs are purely combinational from state and inputs.
// Build option: MULDIV_STALL_EN enables multicycle MUL/DIV/MOD stalling;
// without it those operations complete in a single EX cycle.
module pipe_hazard_ctrl
    import riscv_params_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  address_reg    of_instr,
    input  address_reg    ex_instr,
    input  control_signal ex_ctrl,
    input  logic          ex_branch_taken,
    input  logic          mem_wait,
    output logic          hold_front,
    output logic          hold_ex,
    output logic          hold_all,
    output logic          bubble_ex,
    output logic          bubble_ma,
    output logic          flush_front,
    output logic          ld_use_conflict,
    output logic          md_done
);

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    hazard_state state_q, state_d;
    hazard_state ret_q, ret_d;
    hazard_state eff_state;
    logic [3:0]  cnt_q, cnt_d;

    logic        ld_hazard;
    logic        is_md;
    logic [3:0]  md_lat;

    logic hf_c, hx_c, ha_c, bx_c, bm_c, ff_c, lu_c, md_c;

    ld_use_detect u_ld_use_detect (
        .ex_valid (ex_instr.valid),
        .ex_is_ld (ex_ctrl.isLd),
        .ex_rd    (ex_instr.rd),
        .of_instr (of_instr),
        .hazard   (ld_hazard)
    );

    assign is_md  = ex_instr.valid && (ex_ctrl.isMul || ex_ctrl.isDiv || ex_ctrl.isMod);
    assign md_lat = ex_ctrl.isMul ? MUL_LAT_C : DIV_LAT_C;

    // While frozen, the saved state governs behaviour once mem_wait drops
    assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

    // Fields of EX not needed by hazard detection
    logic unused_ex_fields;
    assign unused_ex_fields = ^{ex_instr.rs1, ex_instr.rs2, ex_instr.I_bit,
                                ex_instr.opcode, ex_ctrl.isSt, ex_ctrl.isBranch};

`ifndef MULDIV_STALL_EN
    logic unused_md_lat;
    assign unused_md_lat = ^md_lat;
`endif

    // Next-state and prioritised hazard actions
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        hf_c    = 1'b0;
        hx_c    = 1'b0;
        ha_c    = 1'b0;
        bx_c    = 1'b0;
        bm_c    = 1'b0;
        ff_c    = 1'b0;
        lu_c    = 1'b0;
        md_c    = 1'b0;
        if (mem_wait) begin
            ha_c    = 1'b1;
            state_d = FREEZE;
            ret_d   = eff_state;
        end else begin
            case (eff_state)
                MD_BUSY: begin
                    if (cnt_q <= 4'd1) begin
                        md_c    = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        hf_c    = 1'b1;
                        hx_c    = 1'b1;
                        bm_c    = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                        state_d = MD_BUSY;
                    end
                end
                default: begin
                    state_d = IDLE;
                    if (is_md) begin
`ifdef MULDIV_STALL_EN
                        if (md_lat <= 4'd1) begin
                            md_c = 1'b1;
                        end else begin
                            hf_c    = 1'b1;
                            hx_c    = 1'b1;
                            bm_c    = 1'b1;
                            cnt_d   = md_lat - 4'd1;
                            state_d = MD_BUSY;
                        end
`else
                        md_c = 1'b1;
`endif
                    end else if (ex_branch_taken) begin
                        ff_c = 1'b1;
                    end else if (ld_hazard) begin
                        lu_c = 1'b1;
                        hf_c = 1'b1;
                        bx_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, return state and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces every output low without waiting for a clock edge
    assign hold_front      = rst_n & hf_c;
    assign hold_ex         = rst_n & hx_c;
    assign hold_all        = rst_n & ha_c;
    assign bubble_ex       = rst_n & bx_c;
    assign bubble_ma       = rst_n & bm_c;
    assign flush_front     = rst_n & ff_c;
    assign ld_use_conflict = rst_n & lu_c;
    assign md_done         = rst_n & md_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed stimulus pushes the
// expected output vector per cycle; a monitor pops and compares on the
// falling edge.
module tb_pipe_hazard_ctrl;
    import riscv_params_pkg::*;

    // Output vector bit order:
    // [7] hold_front [6] hold_ex [5] hold_all [4] bubble_ex
    // [3] bubble_ma  [2] flush_front [1] ld_use_conflict [0] md_done
    localparam logic [7:0] E_NONE   = 8'b0000_0000;
    localparam logic [7:0] E_LDUSE  = 8'b1001_0010;
    localparam logic [7:0] E_MDHOLD = 8'b1100_1000;
    localparam logic [7:0] E_FREEZE = 8'b0010_0000;
    localparam logic [7:0] E_FLUSH  = 8'b0000_0100;
    localparam logic [7:0] E_DONE   = 8'b0000_0001;

    logic          clk = 1'b1;
    logic          rst_n;
    address_reg    of_instr;
    address_reg    ex_instr;
    control_signal ex_ctrl;
    logic          ex_branch_taken;
    logic          mem_wait;
    logic hold_front, hold_ex, hold_all, bubble_ex, bubble_ma;
    logic flush_front, ld_use_conflict, md_done;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(2), .DIV_LAT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .of_instr        (of_instr),
        .ex_instr        (ex_instr),
        .ex_ctrl         (ex_ctrl),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .hold_front      (hold_front),
        .hold_ex         (hold_ex),
        .hold_all        (hold_all),
        .bubble_ex       (bubble_ex),
        .bubble_ma       (bubble_ma),
        .flush_front     (flush_front),
        .ld_use_conflict (ld_use_conflict),
        .md_done         (md_done)
    );

    function automatic address_reg mk(input logic v, input logic [4:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic ibit);
        address_reg a;
        a.valid = v; a.opcode = op; a.rd = rd; a.rs1 = rs1; a.rs2 = rs2; a.I_bit = ibit;
        return a;
    endfunction

    function automatic control_signal ctl(input logic ld, input logic mul,
                                          input logic dv, input logic md);
        control_signal c;
        c = '0;
        c.isLd = ld; c.isMul = mul; c.isDiv = dv; c.isMod = md;
        return c;
    endfunction

    task automatic nop_inputs();
        of_instr        = '0;
        ex_instr        = '0;
        ex_ctrl         = '0;
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
    endtask

    task automatic set_ex_div();
        ex_instr = mk(1'b1, OP_DIV, 5'd9, 5'd1, 5'd2, 1'b0);
        ex_ctrl  = ctl(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_ex_mul();
        ex_instr = mk(1'b1, OP_MUL, 5'd10, 5'd1, 5'd2, 1'b0);
        ex_ctrl  = ctl(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Queue the expected vector for the current inputs, then advance a cycle
    task automatic step(input string nm, input logic [7:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on the falling edge, away from the active edge
    initial begin
        logic [7:0] got, e;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {hold_front, hold_ex, hold_all, bubble_ex,
                       bubble_ma, flush_front, ld_use_conflict, md_done};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", nm, got, e);
                end
            end
        end
    end

    initial begin
        int left;
        // Reset with active-looking inputs: outputs must stay low
        rst_n = 1'b0;
        nop_inputs();
        set_ex_div();
        ex_branch_taken = 1'b1;
        step("reset_a", E_NONE);
        step("reset_b", E_NONE);
        rst_n = 1'b1;
        nop_inputs();
        step("idle", E_NONE);

        // Load-use on rs1, then bubble in EX clears it
        ex_instr = mk(1'b1, OP_LD, 5'd3, 5'd0, 5'd0, 1'b1);
        ex_ctrl  = ctl(1'b1, 1'b0, 1'b0, 1'b0);
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd3, 5'd6, 1'b0);
        step("lduse_rs1", E_LDUSE);
        ex_instr = '0; ex_ctrl = '0;
        step("lduse_after", E_NONE);

        // rs2 matters only when not immediate
        ex_instr = mk(1'b1, OP_LD, 5'd5, 5'd0, 5'd0, 1'b1);
        ex_ctrl  = ctl(1'b1, 1'b0, 1'b0, 1'b0);
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd1, 5'd5, 1'b0);
        step("lduse_rs2_reg", E_LDUSE);
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd1, 5'd5, 1'b1);
        step("lduse_rs2_imm", E_NONE);

        // Store data register (rd) is a source
        ex_instr = mk(1'b1, OP_LD, 5'd7, 5'd0, 5'd0, 1'b1);
        of_instr = mk(1'b1, OP_ST, 5'd7, 5'd1, 5'd2, 1'b1);
        step("lduse_st_rd", E_LDUSE);
        of_instr = mk(1'b1, OP_ADD, 5'd7, 5'd1, 5'd2, 1'b1);
        step("nonst_rd", E_NONE);

        // Invalid EX or OF suppresses the hazard
        ex_instr = mk(1'b0, OP_LD, 5'd3, 5'd0, 5'd0, 1'b1);
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd3, 5'd3, 1'b0);
        step("ex_invalid", E_NONE);
        ex_instr = mk(1'b1, OP_LD, 5'd3, 5'd0, 5'd0, 1'b1);
        of_instr = mk(1'b0, OP_ADD, 5'd4, 5'd3, 5'd3, 1'b0);
        step("of_invalid", E_NONE);

        // Non-load producer with immediate forms: no stall
        ex_instr = mk(1'b1, OP_ADD, 5'd8, 5'd1, 5'd3, 1'b1);
        ex_ctrl  = '0;
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd1, 5'd3, 1'b1);
        step("add_imm_nostall", E_NONE);

        // Branch flush beats load-use
        ex_instr = mk(1'b1, OP_LD, 5'd3, 5'd0, 5'd0, 1'b1);
        ex_ctrl  = ctl(1'b1, 1'b0, 1'b0, 1'b0);
        of_instr = mk(1'b1, OP_ADD, 5'd4, 5'd3, 5'd0, 1'b1);
        ex_branch_taken = 1'b1;
        step("flush", E_FLUSH);
        nop_inputs();
        step("flush_after", E_NONE);

        // Freeze in IDLE, then resume straight into the pending branch
        ex_branch_taken = 1'b1;
        mem_wait = 1'b1;
        step("freeze_idle", E_FREEZE);
        mem_wait = 1'b0;
        step("resume_flush", E_FLUSH);
        nop_inputs();
        step("idle2", E_NONE);

`ifdef MULDIV_STALL_EN
        // DIV with latency 8: 7 held cycles, done on the 8th
        set_ex_div();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 7; i++) step($sformatf("div_hold%0d", i), E_MDHOLD);
        step("div_done", E_DONE);
        nop_inputs();
        step("div_after", E_NONE);

        // DIV frozen for 3 cycles at count 4: 11 cycles total
        set_ex_div();
        for (int i = 0; i < 4; i++) step($sformatf("divf_hold%0d", i), E_MDHOLD);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("divf_frz%0d", i), E_FREEZE);
        mem_wait = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("divf_res%0d", i), E_MDHOLD);
        step("divf_done", E_DONE);
        nop_inputs();
        step("divf_after", E_NONE);

        // MUL latency 2
        set_ex_mul();
        step("mul_hold", E_MDHOLD);
        step("mul_done", E_DONE);
        nop_inputs();

        // Reset mid-MUL: outputs drop at once, op abandoned
        set_ex_mul();
        step("mulr_hold", E_MDHOLD);
        rst_n = 1'b0;
        step("mulr_in_reset", E_NONE);
        rst_n = 1'b1;
        step("mulr_restart", E_MDHOLD);
        step("mulr_done", E_DONE);
        nop_inputs();

        // Reset mid-FREEZE: nothing resumes afterwards
        set_ex_div();
        step("divr_hold", E_MDHOLD);
        mem_wait = 1'b1;
        step("divr_frz", E_FREEZE);
        rst_n = 1'b0;
        step("divr_in_reset", E_NONE);
        rst_n = 1'b1;
        nop_inputs();
        step("divr_after", E_NONE);
`else
        // Single-cycle MUL/DIV/MOD, priority over branch
        set_ex_div();
        ex_branch_taken = 1'b1;
        step("div_single", E_DONE);
        nop_inputs();
        step("div_after", E_NONE);
        set_ex_mul();
        step("mul_single", E_DONE);
        ex_instr = mk(1'b1, OP_MOD, 5'd11, 5'd1, 5'd2, 1'b0);
        ex_ctrl  = ctl(1'b0, 1'b0, 1'b0, 1'b1);
        step("mod_single", E_DONE);
        ex_instr.valid = 1'b0;
        step("mod_invalid", E_NONE);

        // Freeze while DIV in EX, completes on resume
        set_ex_div();
        mem_wait = 1'b1;
        step("div_frz", E_FREEZE);
        mem_wait = 1'b0;
        step("div_resume", E_DONE);

        // Reset with MUL in EX
        set_ex_mul();
        rst_n = 1'b0;
        step("mul_in_reset", E_NONE);
        rst_n = 1'b1;
        step("mul_after_reset", E_DONE);
        nop_inputs();
        step("idle_end", E_NONE);
`endif

        // Scoreboard must be drained
        left = exp_q.size();
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", left);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
